// File: rtl/exe_stage_pkg.sv
// Shared encodings for the execute stage: ALU commands, shift types,
// status bit positions and the multiplier sequencer states.
package exe_stage_pkg;

  typedef enum logic [3:0] {
    CMD_NOP = 4'b0000,
    CMD_MOV = 4'b0001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000,
    CMD_MVN = 4'b1001,
    CMD_MUL = 4'b1010
  } exe_cmd_e;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } mul_state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Rotate right; a zero rotate returns x unchanged (the left shift by 32 yields 0).
  function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] r);
    return (x >> r) | (x << (6'd32 - {1'b0, r}));
  endfunction

endpackage

// File: rtl/exe_stage_if.sv
// ID/EXE inputs and EXE/MEM, IF and hazard-unit outputs of the execute stage.
interface exe_stage_if;
  logic        WB_en_in, mem_read_in, mem_write_in;
  logic        imm_in, branch_in, s_in, carry_bit_in;
  logic [3:0]  EXE_cmd_in;
  logic [31:0] pc_in, Val_Rn_in, Val_Rm_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_in;
  logic [3:0]  dest_in;

  logic        WB_en_out, mem_read_out, mem_write_out;
  logic [31:0] alu_res_out, Val_Rm_out;
  logic [3:0]  dest_out;
  logic        branch_taken_out;
  logic [31:0] branch_addr_out;
  logic [3:0]  status_out;
  logic        exe_stall_out;

  modport master (
    output WB_en_in, mem_read_in, mem_write_in, imm_in, branch_in, s_in, carry_bit_in,
           EXE_cmd_in, pc_in, Val_Rn_in, Val_Rm_in, shift_operand_in, signed_imm_in, dest_in,
    input  WB_en_out, mem_read_out, mem_write_out, alu_res_out, Val_Rm_out, dest_out,
           branch_taken_out, branch_addr_out, status_out, exe_stall_out
  );

  modport slave (
    input  WB_en_in, mem_read_in, mem_write_in, imm_in, branch_in, s_in, carry_bit_in,
           EXE_cmd_in, pc_in, Val_Rn_in, Val_Rm_in, shift_operand_in, signed_imm_in, dest_in,
    output WB_en_out, mem_read_out, mem_write_out, alu_res_out, Val_Rm_out, dest_out,
           branch_taken_out, branch_addr_out, status_out, exe_stall_out
  );
endinterface

// File: rtl/exe_stage_val2_generator.sv
// Second ALU operand: rotated 8-bit immediate, 12-bit memory offset,
// or Rm shifted by an immediate amount.
module val2_generator
  import exe_stage_pkg::*;
(
  input  logic        imm_i,
  input  logic        mem_i,
  input  logic [11:0] shift_op_i,
  input  logic [31:0] val_rm_i,
  output logic [31:0] val2_o
);

  // Operand select and barrel shift
  always_comb begin
    val2_o = val_rm_i;
    if (imm_i) begin
      val2_o = ror32({24'b0, shift_op_i[7:0]}, {shift_op_i[11:8], 1'b0});
    end else if (mem_i) begin
      val2_o = {20'b0, shift_op_i};
    end else begin
      case (shift_op_i[6:5])
        SH_LSL:  val2_o = val_rm_i << shift_op_i[11:7];
        SH_LSR:  val2_o = val_rm_i >> shift_op_i[11:7];
        SH_ASR:  val2_o = $unsigned($signed(val_rm_i) >>> shift_op_i[11:7]);
        SH_ROR:  val2_o = ror32(val_rm_i, shift_op_i[11:7]);
        default: val2_o = val_rm_i;
      endcase
    end
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: Val2 + ALU, branch target, NZCV register and an iterative
// multiplier that freezes the front end while it runs.
//   state | meaning
//   IDLE  | single-cycle pass-through; a MUL latches operands and stalls
//   BUSY  | one MUL_STEP-bit slice of Rm retired per cycle, bubble out
//   DONE  | product and latched control presented, stall released
module exe_stage
  import exe_stage_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MUL_STEP = 4
) (
  input logic        clk,
  input logic        rst,
  exe_stage_if.slave bus
);

  localparam int ITER  = DATA_W / MUL_STEP;
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  mul_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] acc_q, a_q, b_q, mul_part;
  logic [3:0]        dest_q, status_q;
  logic              wb_q, s_q;

  logic [31:0] val2, alu_res, add_b;
  logic [32:0] sum;
  logic [3:0]  alu_flags;
  logic        alu_upd, arith, add_cin, is_mul;

  assign is_mul = (bus.EXE_cmd_in == CMD_MUL);

  val2_generator u_val2 (
    .imm_i      (bus.imm_in),
    .mem_i      (bus.mem_read_in | bus.mem_write_in),
    .shift_op_i (bus.shift_operand_in),
    .val_rm_i   (bus.Val_Rm_in),
    .val2_o     (val2)
  );

  // Partial product of Rn with the current Rm slice, aligned to its weight
  assign mul_part = (a_q * DATA_W'(b_q[int'(cnt_q) * MUL_STEP +: MUL_STEP]))
                    << (int'(cnt_q) * MUL_STEP);

  // ALU result and candidate flags; C/V default to the held register values
  always_comb begin
    alu_res   = '0;
    alu_flags = status_q;
    alu_upd   = 1'b1;
    arith     = 1'b0;
    add_b     = val2;
    add_cin   = 1'b0;
    case (bus.EXE_cmd_in)
      CMD_MOV: alu_res = val2;
      CMD_MVN: alu_res = ~val2;
      CMD_ADD: arith = 1'b1;
      CMD_ADC: begin arith = 1'b1; add_cin = bus.carry_bit_in; end
      CMD_SUB: begin arith = 1'b1; add_b = ~val2; add_cin = 1'b1; end
      CMD_SBC: begin arith = 1'b1; add_b = ~val2; add_cin = bus.carry_bit_in; end
      CMD_AND: alu_res = bus.Val_Rn_in & val2;
      CMD_ORR: alu_res = bus.Val_Rn_in | val2;
      CMD_EOR: alu_res = bus.Val_Rn_in ^ val2;
      default: alu_upd = 1'b0;
    endcase
    // Subtraction as Rn + ~Val2 + cin makes the carry-out equal to NOT borrow
    sum = {1'b0, bus.Val_Rn_in} + {1'b0, add_b} + {32'b0, add_cin};
    if (arith) begin
      alu_res           = sum[31:0];
      alu_flags[FLAG_C] = sum[32];
      alu_flags[FLAG_V] = (bus.Val_Rn_in[31] == add_b[31]) && (sum[31] != bus.Val_Rn_in[31]);
    end
    alu_flags[FLAG_N] = alu_res[31];
    alu_flags[FLAG_Z] = (alu_res == '0);
  end

  // Multiplier sequencer and status register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      dest_q   <= '0;
      wb_q     <= 1'b0;
      s_q      <= 1'b0;
      status_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (is_mul) begin
            a_q     <= bus.Val_Rn_in;
            b_q     <= bus.Val_Rm_in;
            dest_q  <= bus.dest_in;
            wb_q    <= bus.WB_en_in;
            s_q     <= bus.s_in;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= ST_BUSY;
          end else if (bus.s_in && alu_upd) begin
            status_q <= alu_flags;
          end
        end
        ST_BUSY: begin
          acc_q <= acc_q + mul_part;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_q <= ST_DONE;
        end
        ST_DONE: begin
          if (s_q) begin
            status_q[FLAG_N] <= acc_q[DATA_W-1];
            status_q[FLAG_Z] <= (acc_q == '0);
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Output steering: pass-through in IDLE, bubble while busy, product in DONE
  always_comb begin
    bus.WB_en_out        = 1'b0;
    bus.mem_read_out     = 1'b0;
    bus.mem_write_out    = 1'b0;
    bus.branch_taken_out = 1'b0;
    bus.alu_res_out      = '0;
    bus.dest_out         = dest_q;
    bus.Val_Rm_out       = b_q;
    bus.exe_stall_out    = 1'b0;
    bus.status_out       = status_q;
    bus.branch_addr_out  = bus.pc_in + {{6{bus.signed_imm_in[23]}}, bus.signed_imm_in, 2'b00};
    case (state_q)
      ST_IDLE: begin
        bus.dest_out   = bus.dest_in;
        bus.Val_Rm_out = bus.Val_Rm_in;
        if (is_mul) begin
          bus.exe_stall_out = 1'b1;
        end else begin
          bus.WB_en_out        = bus.WB_en_in;
          bus.mem_read_out     = bus.mem_read_in;
          bus.mem_write_out    = bus.mem_write_in;
          bus.branch_taken_out = bus.branch_in;
          bus.alu_res_out      = alu_res;
        end
      end
      ST_BUSY: bus.exe_stall_out = 1'b1;
      ST_DONE: begin
        bus.WB_en_out   = wb_q;
        bus.alu_res_out = acc_q;
      end
      default: ;
    endcase
  end

endmodule
